idma_desc64_apb_submitter: RTL and testbench

//  APB requester feeding the desc64 frontend register file. Accepts 64-bit descriptor

---
 rtl/idma_desc64_apb_submitter.sv | 200 ++++++++++++++++++++
 tb/tb_idma_desc64_apb_submitter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_desc64_apb_submitter.sv
// APB requester that writes 64-bit descriptor addresses into the desc64 frontend's
// DESC_ADDR register, as one beat or as a low/high pair, and reports slave errors and long stalls.
module idma_desc64_apb_submitter #(
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 64,
    parameter logic [AddrWidth-1:0] DescAddrOffset = {AddrWidth{1'b0}},
    parameter logic [2:0]           Prot           = 3'b000,
    parameter int unsigned          StallThreshold = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [63:0]              desc_addr_i,
    input  logic                     desc_valid_i,
    output logic                     desc_ready_o,
    output logic [AddrWidth-1:0]     paddr_o,
    output logic                     psel_o,
    output logic                     penable_o,
    output logic                     pwrite_o,
    output logic [DataWidth-1:0]     pwdata_o,
    output logic [DataWidth/8-1:0]   pstrb_o,
    output logic [2:0]               pprot_o,
    input  logic                     pready_i,
    input  logic                     pslverr_i,
    output logic                     done_o,
    output logic                     err_o,
    output logic [63:0]              err_addr_o,
    output logic                     stall_o
);

    localparam int unsigned          StrbWidth      = DataWidth / 8;
    localparam int unsigned          CntWidth       = $clog2(StallThreshold + 1);
    localparam logic [CntWidth-1:0]  StallLimit     = CntWidth'(StallThreshold);
    localparam logic [AddrWidth-1:0] HighBeatOffset = AddrWidth'(4);
    localparam bit                   SingleBeat     = (DataWidth == 64);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                 r_state;
    logic [63:0]            r_desc;
    logic                   r_beat;
    logic [CntWidth-1:0]    r_cnt;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [AddrWidth-1:0]   r_paddr;
    logic [DataWidth-1:0]   r_pwdata;
    logic [StrbWidth-1:0]   r_pstrb;
    logic                   r_done;
    logic                   r_err;
    logic [63:0]            r_err_addr;
    logic                   r_stall;

    state_e                 w_state_n;
    logic [63:0]            w_desc_n;
    logic                   w_beat_n;
    logic [CntWidth-1:0]    w_cnt_n;
    logic                   w_done_n;
    logic                   w_err_n;
    logic [63:0]            w_err_addr_n;
    logic [AddrWidth-1:0]   w_paddr_n;
    logic [DataWidth-1:0]   w_pwdata_n;
    logic [DataWidth-1:0]   w_beat_data;
    logic                   w_last_beat;
    logic                   w_psel_n;

    assign w_last_beat = SingleBeat ? 1'b1 : r_beat;
    assign w_psel_n    = (w_state_n != ST_IDLE);

    // Slice of the descriptor carried by the beat being set up.
    if (DataWidth == 64) begin : g_wide
        assign w_beat_data = w_desc_n;
    end else begin : g_narrow
        assign w_beat_data = w_beat_n ? w_desc_n[63:32] : w_desc_n[31:0];
    end

    // Transfer sequencing: handshake, SETUP/ACCESS per beat, completion or error.
    always_comb begin
        w_state_n    = r_state;
        w_desc_n     = r_desc;
        w_beat_n     = r_beat;
        w_done_n     = 1'b0;
        w_err_n      = 1'b0;
        w_err_addr_n = r_err_addr;
        case (r_state)
            ST_IDLE: begin
                if (desc_valid_i) begin
                    w_state_n = ST_SETUP;
                    w_desc_n  = desc_addr_i;
                    w_beat_n  = 1'b0;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_n = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    if (pslverr_i) begin
                        // An error aborts the rest of the descriptor.
                        w_state_n    = ST_IDLE;
                        w_err_n      = 1'b1;
                        w_err_addr_n = r_desc;
                    end else if (w_last_beat) begin
                        w_state_n = ST_IDLE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n = ST_SETUP;
                        w_beat_n  = 1'b1;
                    end
                end else begin
                    w_state_n = ST_ACCESS;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // Address and data are loaded on SETUP entry and held through ACCESS.
    always_comb begin
        w_paddr_n  = r_paddr;
        w_pwdata_n = r_pwdata;
        if (w_state_n == ST_SETUP) begin
            w_paddr_n  = DescAddrOffset + (w_beat_n ? HighBeatOffset : {AddrWidth{1'b0}});
            w_pwdata_n = w_beat_data;
        end else begin
            w_paddr_n  = r_paddr;
            w_pwdata_n = r_pwdata;
        end
    end

    // Stall counter: waiting ACCESS cycles, saturating, cleared otherwise.
    always_comb begin
        w_cnt_n = {CntWidth{1'b0}};
        if ((r_state == ST_ACCESS) && !pready_i) begin
            if (r_cnt == StallLimit) begin
                w_cnt_n = r_cnt;
            end else begin
                w_cnt_n = r_cnt + CntWidth'(1'b1);
            end
        end else begin
            w_cnt_n = {CntWidth{1'b0}};
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_desc     <= 64'h0;
            r_beat     <= 1'b0;
            r_cnt      <= {CntWidth{1'b0}};
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= {AddrWidth{1'b0}};
            r_pwdata   <= {DataWidth{1'b0}};
            r_pstrb    <= {StrbWidth{1'b0}};
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= 64'h0;
            r_stall    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_desc     <= w_desc_n;
            r_beat     <= w_beat_n;
            r_cnt      <= w_cnt_n;
            r_psel     <= w_psel_n;
            r_penable  <= (w_state_n == ST_ACCESS);
            r_pwrite   <= w_psel_n;
            r_paddr    <= w_paddr_n;
            r_pwdata   <= w_pwdata_n;
            r_pstrb    <= w_psel_n ? {StrbWidth{1'b1}} : {StrbWidth{1'b0}};
            r_done     <= w_done_n;
            r_err      <= w_err_n;
            r_err_addr <= w_err_addr_n;
            r_stall    <= (w_cnt_n >= StallLimit);
        end
    end

    assign desc_ready_o = (r_state == ST_IDLE);
    assign pprot_o      = Prot;
    assign paddr_o      = r_paddr;
    assign psel_o       = r_psel;
    assign penable_o    = r_penable;
    assign pwrite_o     = r_pwrite;
    assign pwdata_o     = r_pwdata;
    assign pstrb_o      = r_pstrb;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign err_addr_o   = r_err_addr;
    assign stall_o      = r_stall;

endmodule

// File: tb/tb_idma_desc64_apb_submitter.sv
// Bench for idma_desc64_apb_submitter: a 64-bit instance (stall threshold 4) and a 32-bit
// instance (stall threshold 8) checked every cycle against an APB-beat-level reference model.
module tb_idma_desc64_apb_submitter;

    localparam int TH0 = 4;
    localparam int TH1 = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  valid = 2'b00;
    logic [1:0]  pready = 2'b00;
    logic [1:0]  pslverr = 2'b00;
    logic [63:0] addr0 = 64'h0;
    logic [63:0] addr1 = 64'h0;
    int          mode [2] = '{0, 0};

    logic [1:0]  ready, psel, penable, pwrite, done, err, stall;
    logic [31:0] paddr0, paddr1;
    logic [63:0] pwdata0;
    logic [31:0] pwdata1;
    logic [7:0]  pstrb0;
    logic [3:0]  pstrb1;
    logic [2:0]  pprot0, pprot1;
    logic [63:0] err_addr0, err_addr1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idma_desc64_apb_submitter #(
        .AddrWidth(32), .DataWidth(64), .DescAddrOffset(32'h0), .Prot(3'b000), .StallThreshold(TH0)
    ) u_dut64 (
        .clk_i(clk), .rst_i(rst), .desc_addr_i(addr0), .desc_valid_i(valid[0]),
        .desc_ready_o(ready[0]), .paddr_o(paddr0), .psel_o(psel[0]), .penable_o(penable[0]),
        .pwrite_o(pwrite[0]), .pwdata_o(pwdata0), .pstrb_o(pstrb0), .pprot_o(pprot0),
        .pready_i(pready[0]), .pslverr_i(pslverr[0]), .done_o(done[0]), .err_o(err[0]),
        .err_addr_o(err_addr0), .stall_o(stall[0])
    );

    idma_desc64_apb_submitter #(
        .AddrWidth(32), .DataWidth(32), .DescAddrOffset(32'h0), .Prot(3'b101), .StallThreshold(TH1)
    ) u_dut32 (
        .clk_i(clk), .rst_i(rst), .desc_addr_i(addr1), .desc_valid_i(valid[1]),
        .desc_ready_o(ready[1]), .paddr_o(paddr1), .psel_o(psel[1]), .penable_o(penable[1]),
        .pwrite_o(pwrite[1]), .pwdata_o(pwdata1), .pstrb_o(pstrb1), .pprot_o(pprot1),
        .pready_i(pready[1]), .pslverr_i(pslverr[1]), .done_o(done[1]), .err_o(err[1]),
        .err_addr_o(err_addr1), .stall_o(stall[1])
    );

    logic [63:0] a_pwdata [2];
    logic [63:0] a_paddr [2];
    logic [63:0] a_pstrb [2];
    logic [63:0] a_pprot [2];
    logic [63:0] a_err_addr [2];
    logic [63:0] a_addr [2];
    assign a_pwdata[0] = pwdata0;           assign a_pwdata[1] = {32'h0, pwdata1};
    assign a_paddr[0] = {32'h0, paddr0};    assign a_paddr[1] = {32'h0, paddr1};
    assign a_pstrb[0] = {56'h0, pstrb0};    assign a_pstrb[1] = {60'h0, pstrb1};
    assign a_pprot[0] = {61'h0, pprot0};    assign a_pprot[1] = {61'h0, pprot1};
    assign a_err_addr[0] = err_addr0;       assign a_err_addr[1] = err_addr1;
    assign a_addr[0] = addr0;               assign a_addr[1] = addr1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Completer model: mode 0 always ready, 1 random ready/error, 2 never ready, 3 ready with error.
    initial forever begin
        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            case (mode[d])
                0: begin pready[d] = 1'b1; pslverr[d] = 1'b0; end
                1: begin pready[d] = ($urandom_range(0, 9) < 6); pslverr[d] = ($urandom_range(0, 4) == 0); end
                2: begin pready[d] = 1'b0; pslverr[d] = $urandom_range(0, 1) == 1; end
                3: begin pready[d] = 1'b1; pslverr[d] = 1'b1; end
                default: begin pready[d] = 1'b1; pslverr[d] = 1'b0; end
            endcase
        end
    end

    // Reference model: a descriptor becomes a list of APB beats; each beat is one SETUP
    // cycle followed by ACCESS cycles until the completer is ready.
    bit          m_known [2]  = '{0, 0};
    bit          m_active [2] = '{0, 0};
    bit          m_access [2] = '{0, 0};
    bit          m_done [2]   = '{0, 0};
    bit          m_err [2]    = '{0, 0};
    int          m_cur [2]    = '{0, 0};
    int          m_nb [2]     = '{0, 0};
    int          m_wait [2]   = '{0, 0};
    logic [63:0] m_desc [2]   = '{64'h0, 64'h0};
    logic [63:0] m_eaddr [2]  = '{64'h0, 64'h0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_known[d]) begin
                logic [63:0] exp_data;
                int th;
                th = (d == 0) ? TH0 : TH1;
                if (d == 0) exp_data = m_desc[d];
                else if (m_cur[d] == 0) exp_data = {32'h0, m_desc[d][31:0]};
                else exp_data = {32'h0, m_desc[d][63:32]};
                chk($sformatf("psel%0d", d), {63'h0, psel[d]}, {63'h0, m_active[d]});
                chk($sformatf("penable%0d", d), {63'h0, penable[d]}, {63'h0, m_active[d] & m_access[d]});
                chk($sformatf("desc_ready%0d", d), {63'h0, ready[d]}, {63'h0, ~m_active[d]});
                chk($sformatf("done%0d", d), {63'h0, done[d]}, {63'h0, m_done[d]});
                chk($sformatf("err%0d", d), {63'h0, err[d]}, {63'h0, m_err[d]});
                chk($sformatf("err_addr%0d", d), a_err_addr[d], m_eaddr[d]);
                chk($sformatf("stall%0d", d), {63'h0, stall[d]}, {63'h0, (m_wait[d] >= th)});
                chk($sformatf("pprot%0d", d), a_pprot[d], (d == 0) ? 64'h0 : 64'h5);
                if (m_active[d]) begin
                    chk($sformatf("paddr%0d", d), a_paddr[d], 64'(m_cur[d] * 4));
                    chk($sformatf("pwdata%0d", d), a_pwdata[d], exp_data);
                    chk($sformatf("pwrite%0d", d), {63'h0, pwrite[d]}, 64'h1);
                    chk($sformatf("pstrb%0d", d), a_pstrb[d], (d == 0) ? 64'hFF : 64'h0F);
                end
            end
            if (rst) begin
                m_known[d] = 1'b1; m_active[d] = 1'b0; m_access[d] = 1'b0;
                m_done[d] = 1'b0; m_err[d] = 1'b0; m_eaddr[d] = 64'h0; m_wait[d] = 0;
            end else if (m_known[d]) begin
                m_done[d] = 1'b0;
                m_err[d] = 1'b0;
                if (!m_active[d]) begin
                    if (valid[d]) begin
                        m_active[d] = 1'b1; m_access[d] = 1'b0; m_cur[d] = 0; m_wait[d] = 0;
                        m_nb[d] = (d == 0) ? 1 : 2;
                        m_desc[d] = a_addr[d];
                    end
                end else if (!m_access[d]) begin
                    m_access[d] = 1'b1;
                    m_wait[d] = 0;
                end else if (pready[d]) begin
                    m_wait[d] = 0;
                    if (pslverr[d]) begin
                        m_err[d] = 1'b1; m_eaddr[d] = m_desc[d]; m_active[d] = 1'b0;
                    end else begin
                        m_cur[d]++;
                        if (m_cur[d] == m_nb[d]) begin
                            m_active[d] = 1'b0; m_done[d] = 1'b1;
                        end else begin
                            m_access[d] = 1'b0;
                        end
                    end
                end else if (m_wait[d] < 1000) begin
                    m_wait[d]++;
                end
            end
        end
    end

    // Offer a descriptor; returns just after the accepting clock edge.
    task automatic push(input int d, input logic [63:0] a);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        valid[d] = 1'b1;
        if (d == 0) addr0 = a; else addr1 = a;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (ready[d]) ok = 1'b1;
            n++;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL push_timeout dut=%0d actual=no_handshake required=handshake", d);
        end
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        if (d == 0) addr0 = {$urandom, $urandom}; else addr1 = {$urandom, $urandom};
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[d] && n < 300);
        checks++;
        if (!ready[d]) begin
            failures++;
            $display("FAIL idle_timeout dut=%0d actual=busy required=idle", d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_psel0", {63'h0, psel[0]}, 64'h0);
        chk("rst_ready0", {63'h0, ready[0]}, 64'h1);
        chk("rst_paddr0", a_paddr[0], 64'h0);
        chk("rst_pwdata0", a_pwdata[0], 64'h0);
        chk("rst_pstrb0", a_pstrb[0], 64'h0);
        chk("rst_err_addr1", a_err_addr[1], 64'h0);
        chk("rst_ready1", {63'h0, ready[1]}, 64'h1);

        // Single 64-bit beat with an always-ready completer.
        @(posedge clk); #1;
        push(0, 64'h0000_0001_DEAD_BEE0);
        @(negedge clk);
        chk("d64_setup_psel", {62'h0, psel[0], penable[0]}, 64'h2);
        chk("d64_pwdata", a_pwdata[0], 64'h0000_0001_DEAD_BEE0);
        @(negedge clk);
        chk("d64_access", {62'h0, psel[0], penable[0]}, 64'h3);
        @(negedge clk);
        chk("d64_done", {62'h0, done[0], ready[0]}, 64'h3);

        // Two 32-bit beats, psel continuous.
        @(posedge clk); #1;
        push(1, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        chk("d32_b0", {a_paddr[1][31:0], a_pwdata[1][31:0]}, 64'h0000_0000_9ABC_DEF0);
        @(negedge clk);
        @(negedge clk);
        chk("d32_b1", {a_paddr[1][31:0], a_pwdata[1][31:0]}, 64'h0000_0004_1234_5678);
        chk("d32_b1_setup", {62'h0, psel[1], penable[1]}, 64'h2);
        @(negedge clk);
        @(negedge clk);
        chk("d32_done", {62'h0, done[1], psel[1]}, 64'h2);

        // Ten-cycle wait: stall after four waiting cycles, new valid ignored while busy.
        @(posedge clk); #1;
        mode[0] = 2;
        push(0, 64'h0123_4567_89AB_CDEF);
        valid[0] = 1'b1;
        addr0 = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            chk($sformatf("hold_stall_%0d", j), {63'h0, stall[0]}, (j >= 5) ? 64'h1 : 64'h0);
            chk("hold_pwdata", a_pwdata[0], 64'h0123_4567_89AB_CDEF);
        end
        @(posedge clk); #1;
        mode[0] = 0;
        valid[0] = 1'b0;
        @(negedge clk);
        chk("hold_last_access", {61'h0, penable[0], ready[0], stall[0]}, 64'h5);
        @(negedge clk);
        chk("hold_done", {62'h0, done[0], stall[0]}, 64'h2);

        // Slave error on beat 0 aborts beat 1.
        @(posedge clk); #1;
        mode[1] = 3;
        push(1, 64'hA);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        mode[1] = 0;
        @(negedge clk);
        chk("err_pulse", {61'h0, err[1], done[1], psel[1]}, 64'h4);
        chk("err_addr", a_err_addr[1], 64'hA);
        @(posedge clk); #1;
        push(1, 64'h5555_6666_7777_8888);
        repeat (5) @(negedge clk);
        chk("after_err_done", {62'h0, done[1], err[1]}, 64'h2);

        // Reset during ACCESS drops the write.
        @(posedge clk); #1;
        mode[1] = 2;
        push(1, 64'hCAFE_F00D_0000_1111);
        @(negedge clk);
        @(negedge clk);
        chk("mid_access", {62'h0, psel[1], penable[1]}, 64'h3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mode[1] = 0;
        @(negedge clk);
        chk("rst_mid", {60'h0, psel[1], done[1], err[1], ready[1]}, 64'h1);
        @(posedge clk); #1;
        push(1, 64'h0BAD_0BAD_1234_0000);
        repeat (5) @(negedge clk);
        chk("after_rst_done", {63'h0, done[1]}, 64'h1);

        // Randomized traffic on each instance.
        for (int d = 0; d < 2; d++) begin
            @(posedge clk); #1;
            mode[d] = 1;
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                push(d, {$urandom, $urandom});
            end
            mode[d] = 0;
            wait_idle(d);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
